// File: rtl/counter_sched_pkg.sv
// Shared types for the counter scheduler: FSM state encoding and id sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // Default requester count and the matching owner-id width.
  localparam int DEF_NUM_REQ = 2;
  localparam int ID_W        = $clog2(DEF_NUM_REQ);

  // Owner-id width for an arbitrary requester count; never narrower than one bit.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first set request above ptr, plus its id.
// Latency: purely combinational, no state (the pointer lives in the caller).
// Backpressure: none; gnt_any is low when no request is present.
// Ports: req (request vector), ptr (last granted id), gnt (one-hot), gnt_id, gnt_any.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);

  logic [ID_W-1:0] idx;

  // Walk ptr+1, ptr+2, ... wrapping, so the last winner has lowest priority.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Shares one up-counter between NUM_REQ requesters; jobs run start..end, then pulse done.
// Latency: accept -> done_valid is n+2 cycles (n = (end-start) mod 2^W / STEP) plus hold cycles.
// Backpressure: req_ready only to the arbitration winner while IDLE; others wait with valid held.
// Ports: clk/rst; req_valid/req_ready/req_start/req_end job handshake (per-requester slices);
//        hold freezes counting; cnt_value, busy, done_valid/done_id are registered status.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REQ     = 2,
  parameter int STEP        = 1,
  parameter int RESET_VALUE = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_start,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_end,
  input  logic                          hold,
  output logic [DATA_WIDTH-1:0]         cnt_value,
  output logic                          busy,
  output logic                          done_valid,
  output logic [$clog2(NUM_REQ)-1:0]    done_id
);

  localparam int                    IDW    = id_width(NUM_REQ);
  localparam logic [DATA_WIDTH-1:0] STEP_V = DATA_WIDTH'(STEP);
  localparam logic [DATA_WIDTH-1:0] RST_V  = DATA_WIDTH'(RESET_VALUE);
  localparam logic [IDW-1:0]        PTR_RST = IDW'(NUM_REQ - 1);

  sched_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] end_q, end_d;
  logic [IDW-1:0]        owner_q, owner_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                  busy_q;
  logic                  done_valid_q;
  logic [IDW-1:0]        done_id_q;

  logic [NUM_REQ-1:0]    gnt;
  logic [IDW-1:0]        gnt_id;
  logic                  gnt_any;
  logic [DATA_WIDTH-1:0] start_sel;
  logic [DATA_WIDTH-1:0] end_sel;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign start_sel = req_start[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
  assign end_sel   = req_end[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];

  // Ready is only offered while idle; it is also masked in the reset cycle so no
  // requester believes a job was taken when the edge is about to clear everything.
  assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    end_d    = end_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          cnt_d    = start_sel;
          end_d    = end_sel;
          owner_d  = gnt_id;
          rr_ptr_d = gnt_id;
          state_d  = RUN;
        end
      end
      RUN: begin
        // End test has priority over counting and is evaluated even while held.
        if (cnt_q == end_q) begin
          state_d = DONE;
        end else if (!hold) begin
          cnt_d = cnt_q + STEP_V;   // wraps modulo 2^DATA_WIDTH
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= RST_V;
      end_q        <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= PTR_RST;
      busy_q       <= 1'b0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      end_q        <= end_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      busy_q       <= (state_d != IDLE);
      done_valid_q <= (state_d == DONE);
      done_id_q    <= (state_d == DONE) ? owner_d : '0;
    end
  end

  assign cnt_value  = cnt_q;
  assign busy       = busy_q;
  assign done_valid = done_valid_q;
  assign done_id    = done_id_q;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed scenarios plus random traffic against a job-level model.
// Latency: n/a.
// Backpressure: requesters hold valid and values until their accept is observed.
module tb_counter_sched;

  localparam int DW = 8;
  localparam int NR = 2;
  localparam int HL = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_start;
  logic [NR*DW-1:0]  req_end;
  logic              hold;
  logic [DW-1:0]     cnt_value;
  logic              busy;
  logic              done_valid;
  logic [0:0]        done_id;
  logic [DW-1:0]     st [NR];
  logic [DW-1:0]     en [NR];

  // second instance with STEP=2 for the wrap scenario
  logic [NR-1:0]     d2_valid;
  logic [NR-1:0]     d2_ready;
  logic [NR*DW-1:0]  d2_start;
  logic [NR*DW-1:0]  d2_end;
  logic              d2_hold;
  logic [DW-1:0]     d2_cnt;
  logic              d2_busy;
  logic              d2_done;
  logic [0:0]        d2_id;

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_start[g*DW +: DW] = st[g];
    assign req_end[g*DW +: DW]   = en[g];
  end

  counter_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .STEP(1), .RESET_VALUE(0)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_start(req_start), .req_end(req_end), .hold(hold), .cnt_value(cnt_value),
    .busy(busy), .done_valid(done_valid), .done_id(done_id)
  );

  counter_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .STEP(2), .RESET_VALUE(0)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(d2_valid), .req_ready(d2_ready),
    .req_start(d2_start), .req_end(d2_end), .hold(d2_hold), .cnt_value(d2_cnt),
    .busy(d2_busy), .done_valid(d2_done), .done_id(d2_id)
  );

  typedef struct {
    int id;
    int sv;
    int ev;
    int acc_cyc;
    int n;
  } job_t;

  job_t exp_q[$];
  int   cyc = 0;
  bit   hold_log [HL];
  int   n_chk = 0;
  int   n_fail = 0;
  int   acc_cnt [NR];
  int   seen [NR];
  int   m_rr = NR - 1;
  bit   m_act = 1'b0;
  int   m_a = 0;
  int   m_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Cycle in which DONE is shown for a job accepted in cycle a needing n increments:
  // RUN starts at a+1, every non-held RUN cycle before the last increment counts, one
  // more RUN cycle sees the match, then DONE. Returns a huge value if not yet decided by lim.
  function automatic int calc_done(input int a, input int n, input int lim);
    int t;
    int rem;
    t = a + 1;
    rem = n;
    while (rem > 0) begin
      if (t >= lim || t >= HL) return 1 << 30;
      if (!hold_log[t]) rem--;
      t++;
    end
    return t + 1;
  endfunction

  // Reference model: job-level arbitration and acceptance prediction.
  always @(negedge clk) begin : model
    logic [NR-1:0] eg;
    int idx;
    job_t j;
    eg = '0;
    if (cyc < HL) hold_log[cyc] = hold;
    if (rst) begin
      m_act = 1'b0;
      m_rr = NR - 1;
      exp_q.delete();
    end else begin
      if (m_act && calc_done(m_a, m_n, cyc) < cyc) begin
        m_act = 1'b0;
        chk("job_retired_queue", exp_q.size(), 0);
      end
      if (!m_act) begin
        for (int k = 1; k <= NR; k++) begin
          idx = (m_rr + k) % NR;
          if (req_valid[idx]) begin
            eg[idx] = 1'b1;
            m_act = 1'b1;
            m_a = cyc;
            m_n = (int'(en[idx]) - int'(st[idx]) + 256) % 256;
            m_rr = idx;
            j.id = idx; j.sv = int'(st[idx]); j.ev = int'(en[idx]);
            j.acc_cyc = cyc; j.n = m_n;
            exp_q.push_back(j);
            acc_cnt[idx] = acc_cnt[idx] + 1;
            break;
          end
        end
      end
    end
    chk("req_ready", int'(req_ready), int'(eg));
  end

  // Completion monitor: every done pulse must match the oldest outstanding job.
  always @(negedge clk) begin : monitor
    job_t e;
    if (done_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL done_unexpected: done_valid=1 id=%0d with no job outstanding (cycle %0d)", done_id, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("done_id", int'(done_id), e.id);
        chk("done_cnt", int'(cnt_value), e.ev);
        chk("done_cycle", cyc, calc_done(e.acc_cyc, e.n, cyc));
      end
    end
  end

  task automatic drive_req(input int i, input int s, input int e);
    st[i] = DW'(s);
    en[i] = DW'(e);
    req_valid[i] = 1'b1;
  endtask

  // Waits for requester i to be accepted, drops its valid; a = accept cycle.
  task automatic wait_acc(input int i, output int a);
    a = -1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (acc_cnt[i] != seen[i]) begin
        seen[i] = acc_cnt[i];
        a = cyc - 1;
        req_valid[i] = 1'b0;
        break;
      end
    end
    if (a < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: requester %0d never accepted", i);
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic wait_any(output int id);
    id = -1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (id < 0 && acc_cnt[i] != seen[i]) begin
          seen[i] = acc_cnt[i];
          id = i;
        end
      end
      if (id >= 0) break;
    end
  endtask

  initial begin
    int a;
    int id;
    rst = 1'b1;
    hold = 1'b0;
    d2_hold = 1'b0;
    d2_valid = '0;
    d2_start = '0;
    d2_end = '0;
    for (int i = 0; i < NR; i++) begin
      acc_cnt[i] = 0;
      seen[i] = 0;
    end
    // contention: both requesters valid from reset
    st[0] = 8'd10; en[0] = 8'd12;
    st[1] = 8'd20; en[1] = 8'd21;
    req_valid = 2'b11;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done_valid", int'(done_valid), 0);
    chk("reset_done_id", int'(done_id), 0);
    chk("reset_cnt", int'(cnt_value), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int g = 0; g < 4; g++) begin
      wait_any(id);
      chk("contention_grant", id, g % 2);
    end
    req_valid = '0;
    repeat (15) @(posedge clk); #1;

    // single job 3 -> 5
    drive_req(0, 3, 5);
    wait_acc(0, a);
    @(negedge clk); chk("single_cnt_c1", int'(cnt_value), 3); chk("single_busy", int'(busy), 1);
    @(negedge clk); chk("single_cnt_c2", int'(cnt_value), 4);
    @(negedge clk); chk("single_cnt_c3", int'(cnt_value), 5); chk("single_nodone_c3", int'(done_valid), 0);
    @(negedge clk); chk("single_done_c4", int'(done_valid), 1); chk("single_id_c4", int'(done_id), 0);
    @(posedge clk); #1;
    // start == end, offered in cycle 5 of the previous job
    drive_req(0, 9, 9);
    @(negedge clk); chk("ready_again_c5", int'(req_ready), 1);
    wait_acc(0, a);
    @(negedge clk); chk("eq_cnt_c1", int'(cnt_value), 9); chk("eq_nodone_c1", int'(done_valid), 0);
    @(negedge clk); chk("eq_done_c2", int'(done_valid), 1);
    @(posedge clk); #1;

    // hold for three cycles in a 3 -> 5 job
    drive_req(0, 3, 5);
    wait_acc(0, a);
    hold = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); chk("hold_nodone_c6", int'(done_valid), 0);
    @(negedge clk); chk("hold_done_c7", int'(done_valid), 1); chk("hold_cnt_c7", int'(cnt_value), 5);
    @(posedge clk); #1;

    // reset in cycle 2 of a 0 -> 10 job
    drive_req(0, 0, 10);
    wait_acc(0, a);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_req(1, 5, 6);
    drive_req(0, 7, 8);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(cnt_value), 0);
    chk("rst_no_done", int'(done_valid), 0);
    chk("rst_winner", int'(req_ready), 1);
    wait_acc(0, a);
    wait_acc(1, a);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      hold = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NR; i++) begin
        if (acc_cnt[i] != seen[i]) begin
          seen[i] = acc_cnt[i];
          if ($urandom_range(0, 1) == 1) begin
            st[i] = DW'($urandom_range(0, 255));
            en[i] = st[i] + DW'($urandom_range(0, 10));
          end else begin
            req_valid[i] = 1'b0;
          end
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          st[i] = DW'($urandom_range(0, 255));
          en[i] = st[i] + DW'($urandom_range(0, 10));
          req_valid[i] = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    hold = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    // wrap with STEP=2: FC, FE, 00, 02, done on 5th cycle
    d2_start = {8'h00, 8'hFC};
    d2_end = {8'h00, 8'h02};
    d2_valid = 2'b01;
    @(negedge clk); chk("wrap_ready", int'(d2_ready), 1);
    @(posedge clk); #1;
    d2_valid = '0;
    @(negedge clk); chk("wrap_c1", int'(d2_cnt), 8'hFC);
    @(negedge clk); chk("wrap_c2", int'(d2_cnt), 8'hFE);
    @(negedge clk); chk("wrap_c3", int'(d2_cnt), 8'h00);
    @(negedge clk); chk("wrap_c4", int'(d2_cnt), 8'h02); chk("wrap_nodone_c4", int'(d2_done), 0);
    @(negedge clk); chk("wrap_done_c5", int'(d2_done), 1); chk("wrap_id_c5", int'(d2_id), 0);
    @(negedge clk); chk("wrap_idle_c6", int'(d2_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
# counter_sched

Scheduler that shares one up-counter between `NUM_REQ` requesters. Each requester submits a job (start value, end value) over a valid/ready handshake. A round-robin arbiter picks one job, the block loads and runs the counter until the end value, then returns a one-cycle completion tagged with the owner. It sits between requester logic and the shared counting datapath, and replaces direct en/rst/preload driving by clients.

## Interface
- `DATA_WIDTH`, 8, counter and job-value width
- `NUM_REQ`, 2, number of requesters (>= 2)
- `STEP`, 1, increment per counting cycle, applied modulo 2^DATA_WIDTH
- `RESET_VALUE`, 0, value of `cnt_value` after reset
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  NUM_REQ  job request, one bit per requester
- `req_ready`  out  NUM_REQ  job accepted when valid & ready at a clock edge
- `req_start`  in  NUM_REQ*DATA_WIDTH  start values; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- `req_end`  in  NUM_REQ*DATA_WIDTH  end values, same slicing
- `hold`  in  1  freezes counting while high in RUN
- `cnt_value`  out  DATA_WIDTH  current counter value
- `busy`  out  1  high when state != IDLE
- `done_valid`  out  1  one-cycle completion pulse
- `done_id`  out  $clog2(NUM_REQ)  owner of the completed job

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - Arbiter picks the first requester with `req_valid` high, searching upward from `rr_ptr`+1 modulo NUM_REQ.
  - `req_ready` is high only for that requester. All bits are low if no request is valid or state != IDLE. `req_ready` is combinational from state, `rr_ptr` and `req_valid`.
  - On accept: `cnt_value` <= start, `end_q` <= end, `owner` <= i, `rr_ptr` <= i, state -> RUN.
- RUN:
  - If `cnt_value` == `end_q`, go to DONE at the next edge; no increment.
  - Otherwise, if `hold` is low, `cnt_value` <= `cnt_value` + STEP. The sum is truncated to DATA_WIDTH, so it wraps 2^DATA_WIDTH-1 -> 0.
  - If `hold` is high, `cnt_value` holds. The end comparison is still evaluated.
- DONE: `done_valid`=1 and `done_id`=`owner` for exactly one cycle. `cnt_value` holds the end value. Next state is IDLE.
- start == end: the job completes with zero increments.
- Unreachable end: if (end - start) mod 2^DATA_WIDTH is not a multiple of STEP, the job never terminates. Requesters must not issue such jobs.
- Request inputs are ignored outside IDLE; non-granted requesters keep waiting. `hold` is ignored outside RUN.
- Reset (including mid-job):
  - state=IDLE, `cnt_value`=RESET_VALUE, `rr_ptr`=NUM_REQ-1 (requester 0 has first priority).
  - `done_valid`=0, `done_id`=0, `busy`=0, `req_ready`=0 during the reset cycle.
  - An in-flight job is dropped with no completion.

## Timing
- Job accepted in cycle 0, with n = (end - start) mod 2^DATA_WIDTH / STEP and no hold:
  - RUN during cycles 1..n+1, `cnt_value`=start in cycle 1.
  - DONE in cycle n+2.
  - IDLE in cycle n+3, which is the earliest next accept.
- Each hold cycle adds one cycle of latency.
- All outputs except `req_ready` are registered.

## Structure
- Package `counter_sched_pkg` holds:
  - state enum `sched_state_t` {IDLE, RUN, DONE}
  - localparam `ID_W` = $clog2(NUM_REQ)
- Sub-module `rr_arbiter`: combinational one-hot grant from request vector and pointer, plus an id encoder. It is parameterized by NUM_REQ. The pointer register stays in `counter_sched`.

## Test plan
- Single job: req 0 with start=3, end=5 in cycle 0.
  - `cnt_value` 3,4,5 in cycles 1-3.
  - `done_valid`=1, `done_id`=0 in cycle 4.
  - `req_ready[0]` high again in cycle 5.
- Contention: both requesters valid continuously from reset.
  - Grants alternate 0,1,0,1.
  - `req_ready` is never high for both.
  - The waiting requester's values are unchanged at its accept.
- Wrap and step: DATA_WIDTH=8, STEP=2, start=0xFC, end=0x02.
  - Sequence FC, FE, 00, 02.
  - DONE on the 5th cycle after accept.
- Hold and start==end:
  - `hold` high for 3 cycles in a 3->5 job delays done to cycle 7.
  - start=end=9 gives done in cycle 2.
- Reset mid-job: assert `rst` in cycle 2 of a 0->10 job.
  - Next cycle: IDLE, `cnt_value`=RESET_VALUE, no `done_valid`.
  - Req 0 wins the next arbitration.
